// File: rtl/conbus_rr_pkg.sv
// Shared constants for the round-robin Wishbone interconnect: CTI codes, default timeout, index-width helpers.
// No logic; latency and backpressure are not applicable.
package conbus_rr_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int DEFAULT_TIMEOUT = 1024;
  localparam int TMO_W           = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits when there is only one entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conbus_rr_arbiter.sv
// Round-robin grant for NM requesters: the grant is held while hold is high, then re-scanned from last+1.
// Grant registers one edge after a request; no backpressure beyond holding the current owner.
module conbus_rr_arbiter
  import conbus_rr_pkg::*;
#(
  parameter int NM = 2,
  localparam int GW = idx_w(NM)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [NM-1:0] req,
  input  logic          hold,
  output logic          gnt_valid,
  output logic [GW-1:0] gnt
);

  logic          gnt_valid_q, gnt_valid_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] last_q, last_d;
  logic          found;
  logic [GW-1:0] pick;

  // Circular scan starting just after the last granted master; the current
  // owner is only re-scanned when its own cyc is low, so it never re-wins.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= NM; k++) begin
      for (int j = 0; j < NM; j++) begin
        if (!found && req[j] && ((int'(last_q) + k) % NM == j)) begin
          found = 1'b1;
          pick  = GW'(j);
        end
      end
    end
  end

  always_comb begin
    gnt_valid_d = gnt_valid_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    if (!(gnt_valid_q && hold)) begin
      gnt_valid_d = found;
      if (found) begin
        gnt_d  = pick;
        last_d = pick;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gnt_valid_q <= 1'b0;
      gnt_q       <= '0;
      last_q      <= GW'(NM - 1);
    end else begin
      gnt_valid_q <= gnt_valid_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt       = gnt_q;

endmodule

// File: rtl/conbus_rr.sv
// Round-robin Wishbone shared bus: NM masters to NS address-decoded slaves, err on unmapped address or slave timeout.
// One cycle from idle request to slave cyc, combinational ack/err/data return; slaves stall the owner by withholding ack.
module conbus_rr
  import conbus_rr_pkg::*;
#(
  parameter int NM       = 2,
  parameter int NS       = 6,
  parameter int S_ADDR_W = 3,
  // Slave 0 sits in the low bits: 0->000, 1->001, 2->010, 3->100, 4->101, 5->110.
  parameter logic [NS*S_ADDR_W-1:0] S_ADDR = {3'b110, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000},
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [NM*32-1:0] m_adr_i,
  input  logic [NM*32-1:0] m_dat_i,
  input  logic [NM*3-1:0]  m_cti_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  output logic [31:0]      m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [31:0]      s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [2:0]       s_cti_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic [NS-1:0]    s_cyc_o,
  output logic [NS-1:0]    s_stb_o,
  input  logic [NS*32-1:0] s_dat_i,
  input  logic [NS-1:0]    s_ack_i,
  input  logic [NS-1:0]    s_err_i
);

  localparam int GW = idx_w(NM);
  localparam int SW = idx_w(NS);
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

  logic             gnt_valid;
  logic [GW-1:0]    gnt;
  logic             cyc, stb;
  logic [31:0]      adr;
  logic             hit;
  logic [SW-1:0]    ssel;
  logic             sl_ack, sl_err;
  logic             active, tmo_err;
  logic             derr_q, derr_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  conbus_rr_arbiter #(.NM(NM)) u_arb (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req      (m_cyc_i),
    .hold     (cyc),
    .gnt_valid(gnt_valid),
    .gnt      (gnt)
  );

  always_comb begin
    cyc     = 1'b0;
    stb     = 1'b0;
    adr     = '0;
    s_dat_o = '0;
    s_cti_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    for (int j = 0; j < NM; j++) begin
      if (gnt_valid && gnt == GW'(j)) begin
        cyc     = m_cyc_i[j];
        stb     = m_stb_i[j];
        adr     = m_adr_i[j*32 +: 32];
        s_dat_o = m_dat_i[j*32 +: 32];
        s_cti_o = m_cti_i[j*3 +: 3];
        s_sel_o = m_sel_i[j*4 +: 4];
        s_we_o  = m_we_i[j];
      end
    end
  end

  assign s_adr_o = adr;

  // Descending scan so the lowest matching slave index wins.
  always_comb begin
    hit  = 1'b0;
    ssel = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (gnt_valid && adr[31 -: S_ADDR_W] == S_ADDR[i*S_ADDR_W +: S_ADDR_W]) begin
        hit  = 1'b1;
        ssel = SW'(i);
      end
    end
  end

  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    sl_ack  = 1'b0;
    sl_err  = 1'b0;
    m_dat_o = '0;
    for (int i = 0; i < NS; i++) begin
      if (hit && ssel == SW'(i)) begin
        s_cyc_o[i] = cyc;
        s_stb_o[i] = stb;
        sl_ack     = s_ack_i[i];
        sl_err     = s_err_i[i];
        m_dat_o    = s_dat_i[i*32 +: 32];
      end
    end
  end

  // derr toggles against itself so a held strobe to a hole gets one err per access.
  always_comb begin
    active    = cyc & stb;
    tmo_err   = (TIMEOUT != 0) && active && (tmo_cnt_q == TMO_LAST);
    derr_d    = active & ~hit & ~derr_q;
    tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (TIMEOUT == 0 || !active || sl_ack || sl_err || derr_q || tmo_err) tmo_cnt_d = '0;
  end

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    for (int j = 0; j < NM; j++) begin
      if (gnt_valid && gnt == GW'(j)) begin
        m_ack_o[j] = sl_ack;
        m_err_o[j] = sl_err | derr_q | tmo_err;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      derr_q    <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      derr_q    <= derr_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_conbus_rr.sv
// Directed bench for conbus_rr: a 3-master instance with an 8-cycle timeout and a 2-master instance with timeout disabled.
module tb_conbus_rr;
  import conbus_rr_pkg::*;

  localparam int NM = 3;
  localparam int NS = 6;

  logic sys_clk;
  logic sys_rst;

  logic [NM*32-1:0] m_adr, m_dat;
  logic [NM*3-1:0]  m_cti;
  logic [NM*4-1:0]  m_sel;
  logic [NM-1:0]    m_we, m_cyc, m_stb;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o;
  logic [31:0]      s_adr_o, s_dat_o;
  logic [2:0]       s_cti_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o;
  logic [NS*32-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i, s_err_i;
  logic [NS-1:0]    ack_en;

  logic [63:0]      n_adr, n_dat;
  logic [5:0]       n_cti;
  logic [7:0]       n_sel;
  logic [1:0]       n_we, n_cyc, n_stb;
  logic [31:0]      n_dat_o;
  logic [1:0]       n_ack_o, n_err_o;
  logic [31:0]      n_s_adr_o, n_s_dat_o;
  logic [2:0]       n_s_cti_o;
  logic [3:0]       n_s_sel_o;
  logic             n_s_we_o;
  logic [NS-1:0]    n_s_cyc_o, n_s_stb_o;
  logic [NS*32-1:0] n_s_dat_i;
  logic [NS-1:0]    n_s_ack_i, n_s_err_i;

  int tests = 0;
  int fails = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Slaves answer in the same cycle they are strobed, if enabled.
  always_comb s_ack_i = s_stb_o & ack_en;

  conbus_rr #(.NM(NM), .NS(NS), .TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_cti_i(m_cti), .m_sel_i(m_sel),
    .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  conbus_rr #(.NM(2), .NS(NS), .TIMEOUT(0)) dut_nt (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_adr_i(n_adr), .m_dat_i(n_dat), .m_cti_i(n_cti), .m_sel_i(n_sel),
    .m_we_i(n_we), .m_cyc_i(n_cyc), .m_stb_i(n_stb),
    .m_dat_o(n_dat_o), .m_ack_o(n_ack_o), .m_err_o(n_err_o),
    .s_adr_o(n_s_adr_o), .s_dat_o(n_s_dat_o), .s_cti_o(n_s_cti_o), .s_sel_o(n_s_sel_o),
    .s_we_o(n_s_we_o), .s_cyc_o(n_s_cyc_o), .s_stb_o(n_s_stb_o),
    .s_dat_i(n_s_dat_i), .s_ack_i(n_s_ack_i), .s_err_i(n_s_err_i)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_masters();
    m_adr = '0; m_dat = '0; m_cti = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    n_adr = '0; n_dat = '0; n_cti = '0; n_sel = '0; n_we = '0; n_cyc = '0; n_stb = '0;
  endtask

  task automatic do_reset();
    clear_masters();
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_masters();
    sys_rst = 1'b1;
    m_adr = {3{32'h4000_0000}};
    m_cyc = 3'b111;
    m_stb = 3'b111;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    tests++; if (s_cyc_o !== 6'b0) begin fails++; $display("FAIL reset_s_cyc: got %b want %b", s_cyc_o, 6'b0); end
    tests++; if (m_ack_o !== 3'b0) begin fails++; $display("FAIL reset_m_ack: got %b want %b", m_ack_o, 3'b0); end
    tests++; if (m_err_o !== 3'b0) begin fails++; $display("FAIL reset_m_err: got %b want %b", m_err_o, 3'b0); end
    tests++; if (s_adr_o !== 32'h0) begin fails++; $display("FAIL reset_s_adr: got %h want %h", s_adr_o, 32'h0); end
    tests++; if (m_dat_o !== 32'h0) begin fails++; $display("FAIL reset_m_dat: got %h want %h", m_dat_o, 32'h0); end
    clear_masters();
    step();
    sys_rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    ack_en = 6'b000100;
    m_adr[31:0] = 32'h4000_0010;
    m_sel[3:0]  = 4'hF;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    @(negedge sys_clk);
    tests++; if (s_cyc_o !== 6'b0) begin fails++; $display("FAIL single_latency: got %b want %b", s_cyc_o, 6'b0); end
    step();
    @(negedge sys_clk);
    tests++; if (s_cyc_o !== 6'b000100) begin fails++; $display("FAIL single_s_cyc: got %b want %b", s_cyc_o, 6'b000100); end
    tests++; if (s_stb_o !== 6'b000100) begin fails++; $display("FAIL single_s_stb: got %b want %b", s_stb_o, 6'b000100); end
    tests++; if (m_ack_o !== 3'b001) begin fails++; $display("FAIL single_m_ack: got %b want %b", m_ack_o, 3'b001); end
    tests++; if (m_dat_o !== 32'hD000_0002) begin fails++; $display("FAIL single_m_dat: got %h want %h", m_dat_o, 32'hD000_0002); end
    tests++; if (s_adr_o !== 32'h4000_0010) begin fails++; $display("FAIL single_s_adr: got %h want %h", s_adr_o, 32'h4000_0010); end
    tests++; if (s_sel_o !== 4'hF) begin fails++; $display("FAIL single_s_sel: got %h want %h", s_sel_o, 4'hF); end
    step();
    m_cyc = '0;
    m_stb = '0;
    step();
    @(negedge sys_clk);
    tests++; if (s_adr_o !== 32'h0) begin fails++; $display("FAIL single_idle_adr: got %h want %h", s_adr_o, 32'h0); end
    tests++; if (m_dat_o !== 32'h0) begin fails++; $display("FAIL single_idle_dat: got %h want %h", m_dat_o, 32'h0); end
    clear_masters();
  endtask

  task automatic test_round_robin();
    int exp_seq [4] = '{0, 1, 2, 0};
    logic [2:0] want;
    do_reset();
    ack_en = 6'b000100;
    for (int j = 0; j < NM; j++) m_adr[j*32 +: 32] = 32'h4000_0000 | (j << 4);
    m_cyc = 3'b111;
    m_stb = 3'b111;
    step();
    for (int k = 0; k < 4; k++) begin
      want = 3'b001 << exp_seq[k];
      @(negedge sys_clk);
      tests++; if (m_ack_o !== want) begin fails++; $display("FAIL rr_grant_%0d: got %b want %b", k, m_ack_o, want); end
      tests++; if (s_adr_o !== (32'h4000_0000 | (exp_seq[k] << 4))) begin fails++; $display("FAIL rr_adr_%0d: got %h want %h", k, s_adr_o, 32'h4000_0000 | (exp_seq[k] << 4)); end
      step();
      m_cyc[exp_seq[k]] = 1'b0;
      m_stb[exp_seq[k]] = 1'b0;
      @(negedge sys_clk);
      tests++; if (s_cyc_o !== 6'b0) begin fails++; $display("FAIL rr_drop_%0d: got %b want %b", k, s_cyc_o, 6'b0); end
      step();
      m_cyc[exp_seq[k]] = 1'b1;
      m_stb[exp_seq[k]] = 1'b1;
    end
    clear_masters();
    step();
  endtask

  task automatic test_burst_hold();
    logic [2:0] cti_seq [4] = '{CTI_INCR, CTI_INCR, CTI_INCR, CTI_EOB};
    do_reset();
    ack_en = 6'b010100;
    m_adr[63:32] = 32'hA000_0000;
    m_cti[5:3]   = CTI_INCR;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    step();
    m_adr[31:0] = 32'h4000_0010;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_cti[5:3] = cti_seq[b];
      @(negedge sys_clk);
      tests++; if (m_ack_o !== 3'b010) begin fails++; $display("FAIL burst_ack_%0d: got %b want %b", b, m_ack_o, 3'b010); end
      tests++; if (s_cyc_o !== 6'b010000) begin fails++; $display("FAIL burst_s_cyc_%0d: got %b want %b", b, s_cyc_o, 6'b010000); end
      tests++; if (s_cti_o !== cti_seq[b]) begin fails++; $display("FAIL burst_cti_%0d: got %b want %b", b, s_cti_o, cti_seq[b]); end
      step();
    end
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    m_cti[5:3] = '0;
    @(negedge sys_clk);
    tests++; if (m_ack_o !== 3'b000) begin fails++; $display("FAIL burst_release_ack: got %b want %b", m_ack_o, 3'b000); end
    step();
    @(negedge sys_clk);
    tests++; if (m_ack_o !== 3'b001) begin fails++; $display("FAIL burst_next_ack: got %b want %b", m_ack_o, 3'b001); end
    tests++; if (s_cyc_o !== 6'b000100) begin fails++; $display("FAIL burst_next_s_cyc: got %b want %b", s_cyc_o, 6'b000100); end
    clear_masters();
    step();
    step();
  endtask

  task automatic test_unmapped();
    logic [2:0] want_err [5] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b001};
    logic       stb_seq  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    m_adr[31:0] = 32'hE000_0000;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      m_stb[0] = stb_seq[c];
      @(negedge sys_clk);
      tests++; if (m_err_o !== want_err[c]) begin fails++; $display("FAIL unmapped_err_%0d: got %b want %b", c, m_err_o, want_err[c]); end
      tests++; if (s_cyc_o !== 6'b0) begin fails++; $display("FAIL unmapped_s_cyc_%0d: got %b want %b", c, s_cyc_o, 6'b0); end
      step();
    end
    clear_masters();
    @(negedge sys_clk);
    tests++; if (m_err_o !== 3'b000) begin fails++; $display("FAIL unmapped_after: got %b want %b", m_err_o, 3'b000); end
    step();
  endtask

  task automatic test_timeout();
    logic [2:0] want;
    ack_en = 6'b000100;
    m_adr[31:0] = 32'hC000_0000;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    n_adr[31:0] = 32'hC000_0000;
    n_cyc[0] = 1'b1;
    n_stb[0] = 1'b1;
    step();
    for (int c = 1; c <= 17; c++) begin
      want = (c == 8 || c == 16) ? 3'b001 : 3'b000;
      @(negedge sys_clk);
      tests++; if (m_err_o !== want) begin fails++; $display("FAIL timeout_cycle_%0d: got %b want %b", c, m_err_o, want); end
      tests++; if (n_err_o !== 2'b00) begin fails++; $display("FAIL notimeout_cycle_%0d: got %b want %b", c, n_err_o, 2'b00); end
      step();
    end
    @(negedge sys_clk);
    tests++; if (n_s_cyc_o !== 6'b100000) begin fails++; $display("FAIL notimeout_s_cyc: got %b want %b", n_s_cyc_o, 6'b100000); end
    for (int c = 0; c < 40; c++) begin
      step();
      @(negedge sys_clk);
      tests++; if (n_err_o !== 2'b00) begin fails++; $display("FAIL notimeout_long_%0d: got %b want %b", c, n_err_o, 2'b00); end
    end
    clear_masters();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    ack_en = 6'b000100;
    m_adr = {32'h4000_0020, 32'h4000_0010, 32'h4000_0000};
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    step();
    @(negedge sys_clk);
    tests++; if (m_ack_o !== 3'b001) begin fails++; $display("FAIL rstmid_before: got %b want %b", m_ack_o, 3'b001); end
    #2 sys_rst = 1'b1;
    #1;
    tests++; if (s_cyc_o !== 6'b0) begin fails++; $display("FAIL rstmid_s_cyc: got %b want %b", s_cyc_o, 6'b0); end
    tests++; if (m_ack_o !== 3'b0) begin fails++; $display("FAIL rstmid_m_ack: got %b want %b", m_ack_o, 3'b0); end
    m_cyc = 3'b111;
    m_stb = 3'b111;
    #1 sys_rst = 1'b0;
    step();
    @(negedge sys_clk);
    tests++; if (m_ack_o !== 3'b001) begin fails++; $display("FAIL rstmid_first_grant: got %b want %b", m_ack_o, 3'b001); end
    clear_masters();
    step();
  endtask

  initial begin
    sys_rst = 1'b1;
    ack_en  = '0;
    s_err_i = '0;
    n_s_ack_i = '0;
    n_s_err_i = '0;
    n_s_dat_i = '0;
    for (int i = 0; i < NS; i++) s_dat_i[i*32 +: 32] = 32'hD000_0000 | i;
    clear_masters();
    test_reset();
    test_single();
    test_round_robin();
    test_burst_hold();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
